// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the two-port SRAM arbiter.
// State encoding and requester port indices.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester + SramController bundle for the arbiter.
// slave: arbiter side; master: requesters/controller side.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req0In;
  logic              wr0In;
  logic [ADDR_W-1:0] addr0In;
  logic [DATA_W-1:0] wdata0In;
  logic [DATA_W-1:0] rdata0Out;
  logic              done0Out;
  logic              stall0Out;

  logic              req1In;
  logic              wr1In;
  logic [ADDR_W-1:0] addr1In;
  logic [DATA_W-1:0] wdata1In;
  logic [DATA_W-1:0] rdata1Out;
  logic              done1Out;
  logic              stall1Out;

  logic              memWrEnOut;
  logic              memRdEnOut;
  logic [ADDR_W-1:0] memAddrOut;
  logic [DATA_W-1:0] memWdataOut;
  logic [DATA_W-1:0] memRdataIn;
  logic              memReadyIn;

  modport slave (
    input  req0In, wr0In, addr0In, wdata0In,
    input  req1In, wr1In, addr1In, wdata1In,
    input  memRdataIn, memReadyIn,
    output rdata0Out, done0Out, stall0Out,
    output rdata1Out, done1Out, stall1Out,
    output memWrEnOut, memRdEnOut,
    output memAddrOut, memWdataOut
  );

  modport master (
    output req0In, wr0In, addr0In, wdata0In,
    output req1In, wr1In, addr1In, wdata1In,
    output memRdataIn, memReadyIn,
    input  rdata0Out, done0Out, stall0Out,
    input  rdata1Out, done1Out, stall1Out,
    input  memWrEnOut, memRdEnOut,
    input  memAddrOut, memWdataOut
  );

endinterface

// File: rtl/sram_port_arbiter_arb_select.sv
// Winner pick for the arbiter plus port-1 starvation counter.
// Ports: clk, rst, arb_en (arbitration cycle), req0/req1, grant (winning port).
module arb_select
  import sram_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic req0,
  input  logic req1,
  output logic grant
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             at_limit;

  assign at_limit = (starve_cnt == LIMIT);

  // Port 0 normally has priority; a starved port 1 overrides it.
  always_comb begin
    grant = PORT_DATA;
    if (req1 && (!req0 || at_limit))
      grant = PORT_AUX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!req1 || grant == PORT_AUX)
        starve_cnt <= '0;
      else if (!at_limit)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SramController between data port 0 and aux port 1.
// Ports: clk, rst, bus (requesters, done/stall, controller side).
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  sram_port_arbiter_if.slave  bus
);

  arb_state_e state;
  logic       owner;
  logic       lat_wr;
  logic       grant;
  logic       any_req;

  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign any_req = bus.req0In | bus.req1In;

  arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .clk   (clk),
    .rst   (rst),
    .arb_en(state == ST_IDLE),
    .req0  (bus.req0In),
    .req1  (bus.req1In),
    .grant (grant)
  );

  always_comb begin
    sel_wr    = bus.wr0In;
    sel_addr  = bus.addr0In;
    sel_wdata = bus.wdata0In;
    if (grant == PORT_AUX) begin
      sel_wr    = bus.wr1In;
      sel_addr  = bus.addr1In;
      sel_wdata = bus.wdata1In;
    end
  end

  assign bus.stall0Out = bus.req0In & ~bus.done0Out;
  assign bus.stall1Out = bus.req1In & ~bus.done1Out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      owner           <= PORT_DATA;
      lat_wr          <= 1'b0;
      bus.memWrEnOut  <= 1'b0;
      bus.memRdEnOut  <= 1'b0;
      bus.memAddrOut  <= '0;
      bus.memWdataOut <= '0;
      bus.rdata0Out   <= '0;
      bus.rdata1Out   <= '0;
      bus.done0Out    <= 1'b0;
      bus.done1Out    <= 1'b0;
    end else begin
      bus.done0Out <= 1'b0;
      bus.done1Out <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner           <= grant;
            lat_wr          <= sel_wr;
            bus.memWrEnOut  <= sel_wr;
            bus.memRdEnOut  <= ~sel_wr;
            bus.memAddrOut  <= sel_addr;
            bus.memWdataOut <= sel_wdata;
            state           <= ST_ISSUE;
          end
        end
        // Wait for the controller to accept (ready drops).
        ST_ISSUE: begin
          if (!bus.memReadyIn)
            state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (bus.memReadyIn) begin
            bus.memWrEnOut <= 1'b0;
            bus.memRdEnOut <= 1'b0;
            if (!lat_wr) begin
              if (owner == PORT_AUX)
                bus.rdata1Out <= bus.memRdataIn;
              else
                bus.rdata0Out <= bus.memRdataIn;
            end
            if (owner == PORT_AUX)
              bus.done1Out <= 1'b1;
            else
              bus.done0Out <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
